// File: rtl/pwm_ramp_ctrl.sv
// Slew-rate limiter for the pwm duty word: accepts targets over valid/ready and walks
// duty_out toward them by a fixed step once every div enabled cycles; estop zeroes at once.
module pwm_ramp_ctrl #(
  parameter int nbits = 16,
  parameter int step  = 64,
  parameter int div   = 4800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [nbits-1:0] tgt_in,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             estop,
  output logic [nbits-1:0] duty_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RAMP, STOP} state_t;

  localparam int cw = (div > 1) ? $clog2(div) : 1;
  localparam logic [cw-1:0]         cnt_last = cw'(div - 1);
  localparam logic signed [nbits:0] step_s   = (nbits + 1)'(step);
  localparam logic [nbits-1:0]      step_u   = nbits'(step);

  state_t                  state_reg;
  logic [nbits-1:0]        duty_reg;
  logic [nbits-1:0]        target_reg;
  logic [cw-1:0]           cnt_reg;
  logic                    busy_reg;
  logic                    done_reg;

  logic                    accept;
  logic                    tick;
  logic                    last_step;
  logic signed [nbits:0]   diff;
  logic [nbits-1:0]        duty_next;

  assign tgt_ready = !rst && !estop && (state_reg != STOP);
  assign accept    = tgt_valid && tgt_ready;
  assign tick      = en && (cnt_reg == cnt_last);

  // One extra bit keeps the distance signed so both directions share one comparison.
  assign diff      = $signed({1'b0, target_reg}) - $signed({1'b0, duty_reg});
  assign last_step = (diff <= step_s) && (diff >= -step_s);

  always_comb begin
    duty_next = target_reg;
    if (diff > step_s)
      duty_next = duty_reg + step_u;
    else if (diff < -step_s)
      duty_next = duty_reg - step_u;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      duty_reg   <= '0;
      target_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (estop) begin
        state_reg  <= STOP;
        duty_reg   <= '0;
        target_reg <= '0;
        cnt_reg    <= '0;
        busy_reg   <= 1'b0;
      end else begin
        case (state_reg)
          STOP: begin
            state_reg <= IDLE;
          end
          IDLE: begin
            if (accept) begin
              target_reg <= tgt_in;
              cnt_reg    <= '0;
              if (tgt_in == duty_reg) begin
                done_reg <= 1'b1;
              end else begin
                state_reg <= RAMP;
                busy_reg  <= 1'b1;
              end
            end
          end
          RAMP: begin
            // A new target restarts the tick spacing; any coincident tick is dropped.
            if (accept) begin
              target_reg <= tgt_in;
              cnt_reg    <= '0;
              if (tgt_in == duty_reg) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
            end else if (en) begin
              if (tick) begin
                cnt_reg  <= '0;
                duty_reg <= duty_next;
                if (last_step) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                end
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty_out = duty_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl (nbits=10, step=16, div=4): directed table, corner sequences,
// then random traffic checked cycle by cycle against an arithmetic reference model.
module tb_pwm_ramp_ctrl;

  localparam int NB = 10;
  localparam int ST = 16;
  localparam int DV = 4;
  localparam int MAXD = (1 << NB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [NB-1:0] tgt_in = '0;
  logic          tgt_valid = 1'b0;
  logic          tgt_ready;
  logic          estop = 1'b0;
  logic [NB-1:0] duty_out;
  logic          busy;
  logic          done;

  pwm_ramp_ctrl #(.nbits(NB), .step(ST), .div(DV)) dut (
    .clk(clk), .rst(rst), .en(en), .tgt_in(tgt_in), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .estop(estop), .duty_out(duty_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: mode 0 idle, 1 ramping, 2 stopped; elapsed counts enabled cycles
  // since the last accept or step.
  int m_mode = 0;
  int m_duty = 0;
  int m_tgt = 0;
  int m_elapsed = 0;
  bit m_done = 0;
  bit ready_seen;
  int done_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit v, input int t, input bit s);
    m_done = 0;
    if (r) begin
      m_mode = 0; m_duty = 0; m_tgt = 0; m_elapsed = 0;
    end else if (s) begin
      m_mode = 2; m_duty = 0; m_tgt = 0; m_elapsed = 0;
    end else if (m_mode == 2) begin
      m_mode = 0;
    end else if (v) begin
      m_tgt = t; m_elapsed = 0;
      if (t == m_duty) begin
        m_mode = 0; m_done = 1;
      end else begin
        m_mode = 1;
      end
    end else if (m_mode == 1 && e) begin
      m_elapsed++;
      if (m_elapsed == DV) begin
        m_elapsed = 0;
        if (m_tgt > m_duty) m_duty = (m_tgt - m_duty <= ST) ? m_tgt : m_duty + ST;
        else                m_duty = (m_duty - m_tgt <= ST) ? m_tgt : m_duty - ST;
        if (m_duty == m_tgt) begin
          m_mode = 0; m_done = 1;
        end
      end
    end
  endtask

  // One clock: drive after negedge, check ready before the edge, outputs 1 unit after it.
  task automatic cycle(input bit r, input bit e, input bit v, input int t, input bit s);
    bit exp_ready;
    rst = r; en = e; tgt_valid = v; estop = s;
    tgt_in = t[NB-1:0];
    #1;
    exp_ready = !r && !s && (m_mode != 2);
    ready_seen = tgt_ready;
    chk("tgt_ready", int'(tgt_ready), int'(exp_ready));
    if (v && exp_ready) $display("cycle %0d accept tgt=%0d duty=%0d", cyc, t, m_duty);
    @(posedge clk);
    model_update(r, e, v, t, s);
    #1;
    cyc++;
    chk("duty_out", int'(duty_out), m_duty);
    chk("busy", int'(busy), int'(m_mode == 1));
    chk("done", int'(done), int'(m_done));
    if (done) done_cnt++;
    @(negedge clk);
  endtask

  typedef struct {
    bit rst; bit en; bit valid; int tgt; bit estop;
    int duty; bit busy; bit done; bit ready;
  } vec_t;
  vec_t vecs[20];

  initial begin
    int k;
    int frozen;
    int min_duty;
    bit reached;

    // Reset, then accept 64 and expect a step of 16 every 4 cycles.
    vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 64, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 1, 64, 0, 0, 1, 0, 1};
    for (int i = 3; i < 20; i++) begin
      k = i - 2;
      vecs[i] = '{0, 1, 0, 0, 0, (k >= 16) ? 64 : 16 * (k / 4), k < 16, k == 16, 1};
    end

    @(negedge clk);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].tgt, vecs[i].estop);
      chk("tbl_ready", int'(ready_seen), int'(vecs[i].ready));
      chk("tbl_duty", int'(duty_out), vecs[i].duty);
      chk("tbl_busy", int'(busy), int'(vecs[i].busy));
      chk("tbl_done", int'(done), int'(vecs[i].done));
    end

    // Clamp down 64 -> 40: one step of 16, then land exactly on 40.
    done_cnt = 0;
    min_duty = MAXD;
    cycle(0, 1, 1, 40, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (int'(duty_out) < min_duty) min_duty = int'(duty_out);
    end
    chk("clamp_final", int'(duty_out), 40);
    chk("clamp_min", min_duty, 40);
    chk("clamp_done_cnt", done_cnt, 1);

    // Retarget mid-ramp: head for 200, reverse to 0 once duty reaches 56 (40+16).
    cycle(0, 1, 1, 200, 0);
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (int'(duty_out) == 56) reached = 1;
    end
    chk("retgt_reached", int'(reached), 1);
    done_cnt = 0;
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 0);
    chk("retgt_final", int'(duty_out), 0);
    chk("retgt_done_cnt", done_cnt, 1);

    // Estop at duty 96 during a ramp to 300; valid is held the whole time and ignored.
    cycle(0, 1, 1, 300, 0);
    reached = 0;
    for (int i = 0; i < 60 && !reached; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (int'(duty_out) == 96) reached = 1;
    end
    chk("estop_reached", int'(reached), 1);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 500, 1);
    chk("estop_duty", int'(duty_out), 0);
    chk("estop_busy", int'(busy), 0);
    cycle(0, 1, 0, 0, 0);
    #1;
    chk("estop_release_ready", int'(tgt_ready), 1);
    chk("estop_release_duty", int'(duty_out), 0);
    chk("estop_done_cnt", done_cnt, 0);

    // en low for 20 cycles mid-ramp freezes duty; then rst mid-ramp clears it.
    cycle(0, 1, 1, 300, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0);
    frozen = int'(duty_out);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
    chk("en_frozen", int'(duty_out), frozen);
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0);
    chk("en_resume", int'(duty_out), frozen + ST);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    chk("rst_mid_duty", int'(duty_out), 0);
    chk("rst_mid_busy", int'(busy), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, v, s;
      int t;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 79) == 0);
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       t = m_duty;
        1:       t = ($urandom_range(0, 1) == 1) ? MAXD : 0;
        default: t = $urandom_range(0, MAXD);
      endcase
      cycle(r, e, v, t, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
